// File: rtl/uart_sha_pkg.sv
// Shared types and constants for the UART-to-SHA-256 command sequencer.
package uart_sha_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StIssue,
        StWait,
        StSendAck,
        StSendNak,
        StSendDig
    } state_e;

    localparam logic [7:0] CMD_INIT = 8'h01;
    localparam logic [7:0] CMD_NEXT = 8'h02;
    localparam logic [7:0] CMD_READ = 8'h03;

    localparam int unsigned BLOCK_BYTES  = 64;
    localparam int unsigned DIGEST_BYTES = 32;

endpackage

// File: rtl/byte_block_packer.sv
// Big-endian byte-to-block shift register: the first byte loaded ends up in [511:504].
module byte_block_packer
    import uart_sha_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [7:0]   din,
    output logic [511:0] block,
    output logic         full
);

    logic [511:0] block_q;
    logic [5:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            block_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            block_q <= {block_q[503:0], din};
            cnt_q   <= cnt_q + 6'd1;
        end
    end

    assign block = block_q;
    // High while the next load completes the block.
    assign full  = (cnt_q == 6'(BLOCK_BYTES - 1));

endmodule

// File: rtl/uart_sha_ctrl.sv
// Command sequencer: pops framed commands from the UART RX FIFO, drives the SHA-256 core
// and answers with ACK/NAK/digest bytes through the TX FIFO.
module uart_sha_ctrl
    import uart_sha_pkg::*;
#(
    parameter int unsigned DBITS          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TO_BITS        = 20,
    parameter logic [7:0]  ACK_BYTE       = 8'hAC,
    parameter logic [7:0]  NAK_BYTE       = 8'hEE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [DBITS-1:0] read_data,
    output logic             read_uart,
    output logic             write_uart,
    output logic [7:0]       write_data,
    input  logic             sha_ready,
    output logic             sha_init,
    output logic             sha_next,
    output logic [511:0]     sha_block,
    input  logic             sha_digest_valid,
    input  logic [255:0]     sha_digest,
    output logic             busy,
    output logic [7:0]       err_count
);

    state_e               state_q, state_d;
    logic                 pop;
    logic                 is_block_cmd;
    logic                 cmd_next_q;
    logic [TO_BITS-1:0]   to_cnt_q;
    logic [255:0]         dig_q;
    logic                 digest_ok_q;
    logic [4:0]           dig_idx_q;
    logic [7:0]           err_count_q;
    logic                 pk_clear;
    logic                 pk_load;
    logic                 pk_full;

    assign pop          = !reset && !rx_empty && (state_q == StIdle || state_q == StRecv);
    assign is_block_cmd = (read_data == CMD_INIT) || (read_data == CMD_NEXT);
    assign pk_clear     = (state_q == StIdle) && pop && is_block_cmd;
    assign pk_load      = (state_q == StRecv) && pop;

    byte_block_packer u_packer (
        .clk   (clk),
        .reset (reset),
        .clear (pk_clear),
        .load  (pk_load),
        .din   (read_data),
        .block (sha_block),
        .full  (pk_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    if (is_block_cmd) begin
                        state_d = StRecv;
                    end else if (read_data == CMD_READ && digest_ok_q) begin
                        state_d = StSendDig;
                    end else begin
                        state_d = StSendNak;
                    end
                end
            end
            StRecv: begin
                if (pop) begin
                    // A chained block without a prior digest is drained but refused.
                    if (pk_full) begin
                        state_d = (cmd_next_q && !digest_ok_q) ? StSendNak : StIssue;
                    end
                end else if (to_cnt_q == TO_BITS'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StSendNak;
                end
            end
            StIssue:   if (sha_ready) state_d = StWait;
            StWait:    if (sha_digest_valid) state_d = StSendAck;
            StSendAck: state_d = StIdle;
            StSendNak: state_d = StIdle;
            StSendDig: if (dig_idx_q == 5'(DIGEST_BYTES - 1)) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        write_uart = 1'b0;
        write_data = '0;
        sha_init   = 1'b0;
        sha_next   = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StIssue: begin
                    sha_init = sha_ready && !cmd_next_q;
                    sha_next = sha_ready && cmd_next_q;
                end
                StSendAck: begin
                    write_uart = 1'b1;
                    write_data = ACK_BYTE;
                end
                StSendNak: begin
                    write_uart = 1'b1;
                    write_data = NAK_BYTE;
                end
                StSendDig: begin
                    write_uart = 1'b1;
                    write_data = dig_q[{~dig_idx_q, 3'b000} +: 8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_next_q  <= 1'b0;
            to_cnt_q    <= '0;
            dig_q       <= '0;
            digest_ok_q <= 1'b0;
            dig_idx_q   <= '0;
            err_count_q <= '0;
        end else begin
            if (state_q == StIdle && pop) begin
                cmd_next_q <= (read_data == CMD_NEXT);
            end
            if (state_q != StRecv || pop) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TO_BITS'(1);
            end
            if (state_q == StWait && sha_digest_valid) begin
                dig_q       <= sha_digest;
                digest_ok_q <= 1'b1;
            end
            dig_idx_q <= (state_q == StSendDig) ? dig_idx_q + 5'd1 : 5'd0;
            if (state_q == StSendNak && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign read_uart = pop;
    assign busy      = !reset && (state_q != StIdle);
    assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_sha_ctrl.sv
// Self-checking bench: FIFO and SHA-core stand-ins plus a frame-level response model.
module tb_uart_sha_ctrl;
    import uart_sha_pkg::*;

    localparam logic [255:0] AbcDigest =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx_empty = 1'b1;
    logic [7:0]   read_data = '0;
    logic         read_uart;
    logic         write_uart;
    logic [7:0]   write_data;
    logic         sha_ready = 1'b1;
    logic         sha_init;
    logic         sha_next;
    logic [511:0] sha_block;
    logic         sha_digest_valid = 1'b0;
    logic [255:0] sha_digest = '0;
    logic         busy;
    logic [7:0]   err_count;

    uart_sha_ctrl #(
        .DBITS          (8),
        .TIMEOUT_CYCLES (100),
        .TO_BITS        (8),
        .ACK_BYTE       (8'hAC),
        .NAK_BYTE       (8'hEE)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_empty         (rx_empty),
        .read_data        (read_data),
        .read_uart        (read_uart),
        .write_uart       (write_uart),
        .write_data       (write_data),
        .sha_ready        (sha_ready),
        .sha_init         (sha_init),
        .sha_next         (sha_next),
        .sha_block        (sha_block),
        .sha_digest_valid (sha_digest_valid),
        .sha_digest       (sha_digest),
        .busy             (busy),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [7:0]   rx_q[$];
    logic [7:0]   tx_q[$];
    int           tx_edge[$];
    int           cyc = 0;
    bit           do_pop = 0;
    int           n_init = 0;
    int           n_next = 0;
    logic [511:0] cap_block = '0;
    bit           start_seen = 0;
    bit           core_busy = 0;
    bit           auto_rsp = 1;
    bit           force_valid = 0;
    int           rsp_wait = 0;
    int           ready_block = 0;
    logic [255:0] next_digest = '0;
    int           valid_edge = 0;
    int           pop_edge = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task fire_digest();
        sha_digest       = next_digest;
        sha_digest_valid = 1'b1;
        core_busy        = 1'b0;
        valid_edge       = cyc + 1;
    endtask

    // Observe outputs mid-cycle; edges are numbered by the posedge that samples them.
    always @(negedge clk) begin
        do_pop = read_uart;
        if (read_uart) begin
            check("pop_nonempty", rx_empty, 0);
            pop_edge = cyc + 1;
        end
        if (write_uart) begin
            tx_q.push_back(write_data);
            tx_edge.push_back(cyc + 1);
        end
        if (sha_init || sha_next) begin
            check("start_ready", sha_ready, 1);
            check("start_onehot", sha_init & sha_next, 0);
            if (sha_init) n_init++;
            else n_next++;
            cap_block  = sha_block;
            start_seen = 1;
        end
    end

    // Drive FIFO head and SHA core stand-in just after each active edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (do_pop) begin
            do_pop = 0;
            if (rx_q.size() > 0) rx_q.delete(0);
        end
        sha_digest_valid = 1'b0;
        if (start_seen) begin
            start_seen = 0;
            core_busy  = 1'b1;
            rsp_wait   = auto_rsp ? 3 : 0;
        end else if (rsp_wait > 0) begin
            rsp_wait--;
            if (rsp_wait == 0) begin
                check("block_held", sha_block, cap_block);
                fire_digest();
            end
        end
        if (force_valid) begin
            force_valid = 0;
            fire_digest();
        end
        if (ready_block > 0) ready_block--;
        sha_ready = !core_busy && (ready_block == 0);
        rx_empty  = (rx_q.size() == 0);
        read_data = rx_empty ? 8'h00 : rx_q[0];
    end

    task automatic push_block(input logic [7:0] cmd, input logic [511:0] blk);
        rx_q.push_back(cmd);
        for (int i = 0; i < 64; i++) rx_q.push_back(blk[511 - 8 * i -: 8]);
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int k = 0;
        while (tx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        check(tag, tx_q.size(), n);
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32 * i +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [255:0] rand_digest();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32 * i +: 32] = $urandom;
        return d;
    endfunction

    task automatic read_and_check(input logic [255:0] exp, input string tag);
        logic [255:0] got;
        tx_q.delete();
        tx_edge.delete();
        rx_q.push_back(CMD_READ);
        wait_tx(32, 200, {tag, "_len"});
        for (int i = 0; i < 32; i++) got[255 - 8 * i -: 8] = tx_q[i];
        check({tag, "_value"}, got, exp);
        check({tag, "_first_lat"}, tx_edge[0], pop_edge + 1);
        check({tag, "_burst"}, tx_edge[31] - tx_edge[0], 31);
    endtask

    initial begin
        logic [511:0] blk;
        logic [255:0] model_dig;
        int           model_err;
        int           i0;
        int           n_ee;
        model_err = 0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_err", err_count, 0);
        check("rst_block", sha_block, 0);
        check("rst_tx", write_uart, 0);
        check("rst_start", sha_init | sha_next, 0);
        check("rst_pop", read_uart, 0);

        // Digest read before any hash is refused.
        tx_q.delete();
        rx_q.push_back(CMD_READ);
        wait_tx(1, 50, "noddig_len");
        model_err++;
        check("nodig_byte", tx_q[0], 8'hEE);
        check("nodig_err", err_count, model_err);

        // Chained block without a digest: payload drained, no sha_next.
        tx_q.delete();
        push_block(CMD_NEXT, rand_block());
        wait_tx(1, 300, "next_nak_len");
        model_err++;
        check("next_nak_byte", tx_q[0], 8'hEE);
        check("next_nak_nostart", n_next, 0);
        check("next_nak_err", err_count, model_err);

        // Standard padded "abc".
        blk = '0;
        blk[511:480] = 32'h61626380;
        blk[7:0] = 8'h18;
        next_digest = AbcDigest;
        tx_q.delete();
        tx_edge.delete();
        push_block(CMD_INIT, blk);
        wait_tx(1, 300, "abc_ack_len");
        check("abc_ack_byte", tx_q[0], 8'hAC);
        check("abc_init_cnt", n_init, 1);
        check("abc_block", cap_block, 512'h61626380 << 480 | 512'h18);
        check("abc_ack_lat", tx_edge[0], valid_edge + 1);
        model_dig = AbcDigest;
        read_and_check(AbcDigest, "abc_dig");

        // Random chained block while the core holds off ready.
        blk = rand_block();
        next_digest = rand_digest();
        ready_block = 80;
        tx_q.delete();
        push_block(CMD_NEXT, blk);
        wait_tx(1, 400, "next_ack_len");
        check("next_ack_byte", tx_q[0], 8'hAC);
        check("next_cnt", n_next, 1);
        check("next_block", cap_block, blk);
        model_dig = next_digest;
        read_and_check(model_dig, "next_dig");

        // Truncated frame times out; following frame still hashes.
        tx_q.delete();
        rx_q.push_back(CMD_INIT);
        for (int i = 0; i < 20; i++) rx_q.push_back(8'($urandom));
        wait_tx(1, 250, "to_len");
        model_err++;
        check("to_byte", tx_q[0], 8'hEE);
        check("to_err", err_count, model_err);
        check("to_nostart", n_init, 1);
        blk = rand_block();
        next_digest = rand_digest();
        tx_q.delete();
        push_block(CMD_INIT, blk);
        wait_tx(1, 300, "after_to_len");
        check("after_to_ack", tx_q[0], 8'hAC);
        check("after_to_block", cap_block, blk);
        model_dig = next_digest;
        read_and_check(model_dig, "after_to_dig");

        // Unknown commands, then saturate the error counter.
        tx_q.delete();
        rx_q.push_back(8'h7F);
        wait_tx(1, 50, "bad_len");
        model_err++;
        check("bad_byte", tx_q[0], 8'hEE);
        check("bad_err", err_count, model_err);
        tx_q.delete();
        for (int i = 0; i < 256; i++) rx_q.push_back(8'($urandom_range(4, 255)));
        wait_tx(256, 3000, "sat_len");
        model_err = (model_err + 256 > 255) ? 255 : model_err + 256;
        n_ee = 0;
        foreach (tx_q[i]) if (tx_q[i] == 8'hEE) n_ee++;
        check("sat_all_nak", n_ee, 256);
        check("sat_err", err_count, model_err);

        // Reset while waiting on the core; late digest pulse must be ignored.
        auto_rsp = 0;
        i0 = n_init;
        push_block(CMD_INIT, rand_block());
        for (int k = 0; k < 300 && n_init == i0; k++) @(negedge clk);
        check("rw_started", n_init, i0 + 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rw_busy", busy, 0);
        check("rw_outs", {read_uart, write_uart, write_data, sha_init, sha_next}, 0);
        check("rw_block", sha_block, 0);
        check("rw_err", err_count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_err = 0;
        auto_rsp = 1;
        next_digest = rand_digest();
        tx_q.delete();
        force_valid = 1;
        repeat (4) @(negedge clk);
        check("rw_stray_tx", tx_q.size(), 0);
        check("rw_stray_busy", busy, 0);
        rx_q.push_back(CMD_READ);
        wait_tx(1, 50, "rw_read_len");
        model_err++;
        check("rw_read_nak", tx_q[0], 8'hEE);
        check("rw_read_err", err_count, model_err);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
